regfile_ctx: RTL and testbench

REGFILE_CTX -- requirements
Module: regfile_ctx

---
 rtl/regfile_ctx.sv | 113 +++++++++++
 tb/tb_regfile_ctx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx.sv
// Context save/restore sequencer for an 8-entry register file.
// Save streams R0..R7 out over a valid/ready port, one register read cycle
// followed by one transmit cycle per word. Restore accepts eight words from a
// valid/ready port and writes them to R0..R7 in order, one per accepted beat.
module regfile_ctx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             save_req,
  input  logic             restore_req,
  output logic             busy,
  output logic             done,
  output logic [2:0]       rf_src,
  input  logic [WIDTH-1:0] rf_data,
  output logic             rf_load,
  output logic [2:0]       rf_dest,
  output logic [WIDTH-1:0] rf_in,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SAVE_RD = 3'd1;
  localparam logic [2:0] SAVE_TX = 3'd2;
  localparam logic [2:0] RESTORE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [2:0] LAST_IDX = 3'd7;

  logic [2:0]       state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] out_data_q;

  // Sequencer: state and word counter; save has priority over restore in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (save_req) begin
            state <= SAVE_RD;
          end else if (restore_req) begin
            state <= RESTORE;
          end
        end
        SAVE_RD: begin
          state <= SAVE_TX;
        end
        SAVE_TX: begin
          if (out_ready) begin
            if (cnt == LAST_IDX) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 3'd1;
              state <= SAVE_RD;
            end
          end
        end
        RESTORE: begin
          if (in_valid) begin
            if (cnt == LAST_IDX) begin
              state <= DONE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Save word capture: latch the read port in the read cycle so the word stays
  // stable for however long the consumer stalls in the transmit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
    end else if (state == SAVE_RD) begin
      out_data_q <= rf_data;
    end
  end

  // Output decode: indices all follow the counter, handshakes follow the state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    rf_src    = cnt;
    rf_dest   = cnt;
    out_idx   = cnt;
    out_data  = out_data_q;
    out_valid = (state == SAVE_TX);
    in_ready  = (state == RESTORE);
    rf_load   = (state == RESTORE) && in_valid;
    rf_in     = in_data;
  end

endmodule

// File: tb/tb_regfile_ctx.sv
// Bench for regfile_ctx: an 8-entry register file environment, a transaction
// level model of the save/restore protocol checked every cycle, and directed
// scenarios with literal expectations.
module tb_regfile_ctx;

  logic        clk;
  logic        reset;
  logic        save_req;
  logic        restore_req;
  logic        busy;
  logic        done;
  logic [2:0]  rf_src;
  logic [15:0] rf_data;
  logic        rf_load;
  logic [2:0]  rf_dest;
  logic [15:0] rf_in;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  regfile_ctx #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .rf_src(rf_src), .rf_data(rf_data),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: preload Rn = 0x1111*n, otherwise accept writes.
  logic [15:0] regs [8];
  logic        preload;
  assign rf_data = regs[rf_src];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'(16'h1111 * i);
    end else if (rf_load) begin
      regs[rf_dest] <= rf_in;
    end
  end

  int tests = 0;
  int fails = 0;

  // Model state: mode 0 idle, 1 save, 2 restore, 3 completion cycle.
  int          mode = 0;
  int          phase = 0;
  int          sidx = 0;
  int          ridx = 0;
  bit          model_valid = 0;
  logic [15:0] mrf [8];
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          done_cnt = 0;
  int          load_cnt = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic [2:0]  prev_idx;
  logic [15:0] cap [$];
  int          hs_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task compare();
    int exp_idx;
    if (model_valid) begin
      exp_idx = (mode == 1) ? sidx : (mode == 2) ? ridx : (mode == 3) ? 7 : 0;
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("done", 32'(done), 32'(mode == 3));
      chk("out_valid", 32'(out_valid), 32'(mode == 1 && phase == 1));
      chk("in_ready", 32'(in_ready), 32'(mode == 2));
      chk("rf_load", 32'(rf_load), 32'(mode == 2 && in_valid));
      chk("rf_in", 32'(rf_in), 32'(in_data));
      chk("rf_src", 32'(rf_src), 32'(exp_idx));
      chk("rf_dest", 32'(rf_dest), 32'(exp_idx));
      chk("out_idx", 32'(out_idx), 32'(exp_idx));
      if (mode == 1 && phase == 1) chk("out_data", 32'(out_data), 32'(mrf[sidx]));
      if (mode == 3) chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
      if (prev_stall) begin
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_idx", 32'(out_idx), 32'(prev_idx));
        chk("stall_valid", 32'(out_valid), 32'd1);
      end
    end
    prev_stall = model_valid && out_valid && !out_ready && !reset;
    prev_data  = out_data;
    prev_idx   = out_idx;
    if (model_valid && out_valid && !out_ready) stall_cnt++;
    if (reset) begin
      mode = 0; phase = 0; sidx = 0; ridx = 0; model_valid = 1;
    end else if (model_valid) begin
      case (mode)
        0: begin
          if (save_req) begin mode = 1; phase = 0; sidx = 0; end
          else if (restore_req) begin mode = 2; ridx = 0; end
        end
        1: begin
          if (phase == 0) phase = 1;
          else if (out_ready) begin
            cap.push_back(out_data);
            hs_cyc.push_back(cyc);
            last_hs_cyc = cyc;
            if (sidx == 7) mode = 3;
            else begin sidx++; phase = 0; end
          end
        end
        2: begin
          if (in_valid) begin
            mrf[ridx] = in_data;
            load_cnt++;
            last_hs_cyc = cyc;
            if (ridx == 7) mode = 3;
            else ridx++;
          end
        end
        default: begin
          done_cnt++;
          mode = 0;
        end
      endcase
    end
    cyc++;
  endtask

  task tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
    chk(name, 32'(done_cnt - d0), 32'd1);
    tick();
  endtask

  int d0, l0, req_cyc;

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = 16'(16'h1111 * i);
    reset = 1'b1; preload = 1'b1;
    save_req = 1'b0; restore_req = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      save_req = 1'($urandom); restore_req = 1'($urandom);
      out_ready = 1'($urandom); in_valid = 1'($urandom); in_data = 16'($urandom);
      tick();
    end
    reset = 1'b0; preload = 1'b0;
    save_req = 1'b0; restore_req = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h5A5A;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rf_load", 32'(rf_load), 32'd0);
    chk("rst_rf_src", 32'(rf_src), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_rf_in", 32'(rf_in), 32'h5A5A);
    in_valid = 1'b0; in_data = '0;
    tick();

    // Plain save with the consumer always ready.
    cap.delete(); hs_cyc.delete();
    d0 = done_cnt; req_cyc = cyc;
    save_req = 1'b1; out_ready = 1'b1;
    tick();
    save_req = 1'b0;
    wait_done("save_done", d0);
    chk("save_words", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk("save_word_val", 32'(cap[i]), 32'(16'h1111 * i));
    if (hs_cyc.size() == 8) begin
      chk("save_first_hs", 32'(hs_cyc[0] - req_cyc), 32'd2);
      for (int i = 0; i < 7; i++) chk("save_gap", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd2);
    end
    chk("save_busy_fall", 32'(busy), 32'd0);

    // Save with three cycles of backpressure on word 2.
    cap.delete(); hs_cyc.delete(); stall_cnt = 0;
    d0 = done_cnt; req_cyc = cyc;
    save_req = 1'b1; out_ready = 1'b1;
    tick();
    save_req = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      out_ready = !((cyc - req_cyc) >= 6 && (cyc - req_cyc) <= 8);
      tick();
    end
    chk("bp_done", 32'(done_cnt - d0), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_stalls", 32'(stall_cnt), 32'd3);
    chk("bp_words", 32'(cap.size()), 32'd8);
    if (cap.size() == 8) begin
      chk("bp_word2", 32'(cap[2]), 32'h2222);
      chk("bp_word3", 32'(cap[3]), 32'h3333);
      chk("bp_word7", 32'(cap[7]), 32'h7777);
    end

    // Restore with a one-cycle gap between words.
    d0 = done_cnt; l0 = load_cnt;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      in_valid = (i % 2 == 0);
      in_data = 16'(16'hA000 + ridx);
      tick();
    end
    chk("rs_done", 32'(done_cnt - d0), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("rs_loads", 32'(load_cnt - l0), 32'd8);
    for (int i = 0; i < 8; i++) chk("rs_reg", 32'(regs[i]), 32'(16'hA000 + i));

    // Simultaneous requests: save wins; a restore pulse mid-save is ignored.
    cap.delete(); hs_cyc.delete();
    d0 = done_cnt; l0 = load_cnt;
    save_req = 1'b1; restore_req = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      restore_req = (i == 3);
      tick();
    end
    restore_req = 1'b0;
    chk("both_done", 32'(done_cnt - d0), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("both_no_load", 32'(load_cnt - l0), 32'd0);
    chk("both_words", 32'(cap.size()), 32'd8);
    if (cap.size() == 8) begin
      chk("both_word0", 32'(cap[0]), 32'hA000);
      chk("both_word5", 32'(cap[5]), 32'hA005);
    end
    chk("both_reg0", 32'(regs[0]), 32'hA000);

    // Reset after three restore words, then a fresh restore.
    l0 = load_cnt;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 10 && (load_cnt - l0) < 3; i++) begin
      in_valid = 1'b1;
      in_data = 16'(16'hB000 + ridx);
      tick();
    end
    chk("mid_loads", 32'(load_cnt - l0), 32'd3);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_out_data", 32'(out_data), 32'd0);
    chk("mid_rf_dest", 32'(rf_dest), 32'd0);
    for (int i = 0; i < 3; i++) chk("mid_reg_written", 32'(regs[i]), 32'(16'hB000 + i));
    for (int i = 3; i < 8; i++) chk("mid_reg_kept", 32'(regs[i]), 32'(16'hA000 + i));
    d0 = done_cnt; l0 = load_cnt;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      in_valid = 1'b1;
      in_data = 16'(16'hC000 + ridx);
      tick();
    end
    chk("re_done", 32'(done_cnt - d0), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("re_loads", 32'(load_cnt - l0), 32'd8);
    chk("re_reg0", 32'(regs[0]), 32'hC000);
    chk("re_reg7", 32'(regs[7]), 32'hC007);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
